// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one 8-bit UART transmitter between NUM_REQ sensor-side requesters.
// Each requester offers a two-byte message (command/status byte first, data
// byte second). A round-robin pointer picks the next requester. The block
// latches that requester's message, feeds both bytes to the transmitter one
// at a time, and paces itself on the transmitter's done flag. When the second
// byte has gone out, it acknowledges the requester and advances the pointer.
//
// Ports
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous active-high reset
//   i_Req        level request per requester, held until its o_Ack pulse
//   i_Msg        16 bits per requester: [16k+15:16k+8] first byte,
//                [16k+7:16k] second byte
//   o_Grant      one-hot pulse when a requester's message is latched
//   o_Ack        one-hot pulse when that requester's second byte is finished
//   o_Busy       high from the grant cycle through the ack cycle
//   o_Tx_DV      one-cycle data-valid strobe to the transmitter
//   o_Tx_Byte    byte to the transmitter, held until the next load
//   i_Tx_Active  transmitter busy flag
//   i_Tx_Done    transmitter done flag (high 1-2 cycles after each stop bit)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic [NUM_REQ-1:0]      i_Req,
    input  logic [16*NUM_REQ-1:0]   i_Msg,
    output logic [NUM_REQ-1:0]      o_Grant,
    output logic [NUM_REQ-1:0]      o_Ack,
    output logic                    o_Busy,
    output logic                    o_Tx_DV,
    output logic [7:0]              o_Tx_Byte,
    input  logic                    i_Tx_Active,
    input  logic                    i_Tx_Done
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOAD1      = 3'd1;
    localparam logic [2:0] WAIT1_DONE = 3'd2;
    localparam logic [2:0] WAIT1_CLR  = 3'd3;
    localparam logic [2:0] LOAD2      = 3'd4;
    localparam logic [2:0] WAIT2_DONE = 3'd5;
    localparam logic [2:0] WAIT2_CLR  = 3'd6;
    localparam logic [2:0] ACK        = 3'd7;

    logic [2:0]          state_reg;
    logic [2:0]          rr_ptr_reg;
    logic [2:0]          idx_reg;
    logic [15:0]         msg_reg;
    logic [NUM_REQ-1:0]  grant_reg;
    logic [NUM_REQ-1:0]  ack_reg;
    logic                busy_reg;
    logic                tx_dv_reg;
    logic [7:0]          tx_byte_reg;

    // Requests and messages padded out to eight slots so a 3-bit index can
    // select them without width juggling; unused slots read as zero.
    logic [7:0]          req_pad;
    logic [15:0]         msg_arr [0:7];

    assign req_pad = 8'(i_Req);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_msg
            if (gi < NUM_REQ) begin : g_used
                assign msg_arr[gi] = i_Msg[16*gi +: 16];
            end else begin : g_unused
                assign msg_arr[gi] = 16'h0000;
            end
        end
    endgenerate

    // Candidate gi is the requester gi places above the pointer, wrapping at
    // NUM_REQ. The pointer is always below NUM_REQ, so one subtraction
    // is enough to wrap.
    logic [2:0]          cand_idx [0:NUM_REQ-1];
    logic [NUM_REQ-1:0]  req_rot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [3:0] sum;
            assign sum          = {1'b0, rr_ptr_reg} + 4'(gi);
            assign cand_idx[gi] = (sum >= 4'(NUM_REQ)) ? 3'(sum - 4'(NUM_REQ)) : sum[2:0];
            assign req_rot[gi]  = req_pad[cand_idx[gi]];
        end
    endgenerate

    // The lowest set rotated bit wins, so the search runs downward and the
    // last hit overwrites the earlier ones.
    logic        win_found;
    logic [2:0]  win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_idx   = cand_idx[i];
            end
        end
    end

    logic [NUM_REQ-1:0]  grant_next;
    logic [NUM_REQ-1:0]  ack_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant_next[gi] = (win_idx == 3'(gi));
            assign ack_next[gi]   = (idx_reg == 3'(gi));
        end
    endgenerate

    logic [2:0] rr_ptr_next;
    assign rr_ptr_next = (idx_reg == 3'(NUM_REQ - 1)) ? 3'd0 : idx_reg + 3'd1;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= 3'd0;
            idx_reg     <= 3'd0;
            msg_reg     <= 16'h0000;
            grant_reg   <= '0;
            ack_reg     <= '0;
            busy_reg    <= 1'b0;
            tx_dv_reg   <= 1'b0;
            tx_byte_reg <= 8'h00;
        end else begin
            // Strobes are one cycle wide by construction.
            grant_reg <= '0;
            ack_reg   <= '0;
            tx_dv_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (win_found && !i_Tx_Active) begin
                        msg_reg   <= msg_arr[win_idx];
                        idx_reg   <= win_idx;
                        grant_reg <= grant_next;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD1;
                    end else begin
                        // Busy stays high through the ack cycle and drops
                        // here, on the first idle cycle without a new grant.
                        busy_reg  <= 1'b0;
                    end
                end
                LOAD1: begin
                    tx_dv_reg   <= 1'b1;
                    tx_byte_reg <= msg_reg[15:8];
                    state_reg   <= WAIT1_DONE;
                end
                WAIT1_DONE: begin
                    if (i_Tx_Done) state_reg <= WAIT1_CLR;
                end
                WAIT1_CLR: begin
                    // Wait for done to clear so the transmitter is back in
                    // idle and will accept the next strobe.
                    if (!i_Tx_Done) state_reg <= LOAD2;
                end
                LOAD2: begin
                    tx_dv_reg   <= 1'b1;
                    tx_byte_reg <= msg_reg[7:0];
                    state_reg   <= WAIT2_DONE;
                end
                WAIT2_DONE: begin
                    if (i_Tx_Done) state_reg <= WAIT2_CLR;
                end
                WAIT2_CLR: begin
                    if (!i_Tx_Done) state_reg <= ACK;
                end
                ACK: begin
                    ack_reg    <= ack_next;
                    rr_ptr_reg <= rr_ptr_next;
                    state_reg  <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_Grant   = grant_reg;
    assign o_Ack     = ack_reg;
    assign o_Busy    = busy_reg;
    assign o_Tx_DV   = tx_dv_reg;
    assign o_Tx_Byte = tx_byte_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Instance A has NUM_REQ=2. It drives a behavioural UART transmitter with
// CLKS_PER_BIT=4, and a serial receiver decodes that line. Instance B has
// NUM_REQ=3 and uses a simple done-pulse responder for the wrap case.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // ---------------- instance A (2 requesters) ----------------
    logic [1:0]  req_a = 2'b00;
    logic [31:0] msg_a = 32'h0;
    logic [1:0]  a_grant, a_ack;
    logic        a_busy, a_dv;
    logic [7:0]  a_byte;
    logic        tx_active = 1'b0;
    logic        tx_done   = 1'b0;

    uart_tx_arbiter #(.NUM_REQ(2)) dut_a (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req       (req_a),
        .i_Msg       (msg_a),
        .o_Grant     (a_grant),
        .o_Ack       (a_ack),
        .o_Busy      (a_busy),
        .o_Tx_DV     (a_dv),
        .o_Tx_Byte   (a_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done)
    );

    // Behavioural UART transmitter: start bit, 8 data bits LSB first, and a
    // stop bit, each C clocks long. Done is then high for 2 cycles. It ignores
    // the arbiter's reset and finishes any byte it has started.
    logic [1:0]  tx_st   = 2'd0;
    logic [9:0]  tx_sh   = 10'h3FF;
    int          tx_bit  = 0;
    int          tx_clk  = 0;
    int          tx_dcnt = 0;
    logic        serial;

    assign serial = (tx_st == 2'd1) ? tx_sh[tx_bit] : 1'b1;

    always @(posedge clk) begin
        case (tx_st)
            2'd0: begin
                tx_done <= 1'b0;
                if (a_dv) begin
                    tx_sh     <= {1'b1, a_byte, 1'b0};
                    tx_bit    <= 0;
                    tx_clk    <= 0;
                    tx_active <= 1'b1;
                    tx_st     <= 2'd1;
                end
            end
            2'd1: begin
                if (tx_clk == C - 1) begin
                    tx_clk <= 0;
                    if (tx_bit == 9) begin
                        tx_st     <= 2'd2;
                        tx_active <= 1'b0;
                        tx_done   <= 1'b1;
                        tx_dcnt   <= 0;
                    end else begin
                        tx_bit <= tx_bit + 1;
                    end
                end else begin
                    tx_clk <= tx_clk + 1;
                end
            end
            default: begin
                tx_dcnt <= tx_dcnt + 1;
                if (tx_dcnt == 1) begin
                    tx_done <= 1'b0;
                    tx_st   <= 2'd0;
                end
            end
        endcase
    end

    // Serial receiver. It samples mid-bit, counting from the first low
    // sample seen on the line.
    logic        rx_busy = 1'b0;
    int          rx_k    = 0;
    logic [7:0]  rx_sh   = 8'h00;
    logic [7:0]  rx_log [$];

    always @(posedge clk) begin
        if (!rx_busy) begin
            if (!serial) begin
                rx_busy <= 1'b1;
                rx_k    <= 0;
            end
        end else begin
            rx_k <= rx_k + 1;
            if (rx_k == 9 * C + C / 2) begin
                rx_busy <= 1'b0;
                rx_log.push_back(rx_sh);
            end else if (rx_k > C && (rx_k % C) == C / 2) begin
                rx_sh <= {serial, rx_sh[7:1]};
            end
        end
    end

    // Output logs for instance A, sampled on the falling edge.
    logic [7:0]  dv_log  [$];
    logic [1:0]  g_log   [$];
    logic [1:0]  ack_log [$];

    always @(negedge clk) begin
        if (a_dv)          dv_log.push_back(a_byte);
        if (a_grant != 0)  g_log.push_back(a_grant);
        if (a_ack != 0)    ack_log.push_back(a_ack);
    end

    // ---------------- instance B (3 requesters, wrap case) ----------------
    logic [2:0]  req_b = 3'b000;
    logic [47:0] msg_b = {16'h3031, 16'h2021, 16'h1011};
    logic [2:0]  b_grant, b_ack;
    logic        b_busy, b_dv;
    logic [7:0]  b_byte;
    logic        b_active = 1'b0;
    logic        b_done   = 1'b0;
    int          b_cnt    = 0;
    logic [2:0]  b_glog [$];

    uart_tx_arbiter #(.NUM_REQ(3)) dut_b (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req       (req_b),
        .i_Msg       (msg_b),
        .o_Grant     (b_grant),
        .o_Ack       (b_ack),
        .o_Busy      (b_busy),
        .o_Tx_DV     (b_dv),
        .o_Tx_Byte   (b_byte),
        .i_Tx_Active (b_active),
        .i_Tx_Done   (b_done)
    );

    // Short fake transmitter: busy for a few cycles, then done for 2 cycles.
    always @(posedge clk) begin
        if (b_dv) begin
            b_cnt    <= 1;
            b_active <= 1'b1;
        end else if (b_cnt != 0) begin
            b_cnt <= b_cnt + 1;
            if (b_cnt == 6) begin
                b_active <= 1'b0;
                b_done   <= 1'b1;
            end
            if (b_cnt == 8) begin
                b_done <= 1'b0;
                b_cnt  <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (b_grant != 0) b_glog.push_back(b_grant);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_log.size()) return rx_log[i];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] dv_at(input int i);
        if (i < dv_log.size()) return dv_log[i];
        return 8'hxx;
    endfunction

    function automatic logic [1:0] g_at(input int i);
        if (i < g_log.size()) return g_log[i];
        return 2'bxx;
    endfunction

    function automatic logic [2:0] bg_at(input int i);
        if (i < b_glog.size()) return b_glog[i];
        return 3'bxxx;
    endfunction

    // Wait on falling edges until n acks have been seen on A. Each
    // requester drops its bit in its ack cycle. With rearm set, both
    // requests are raised again one cycle later.
    task automatic run_acks_a(input int n, input bit rearm, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (a_ack != 0) begin
                got++;
                $display("A ack=%b grant_count=%0d t=%0t", a_ack, g_log.size(), $time);
                req_a = req_a & ~a_ack;
            end else if (rearm) begin
                req_a = 2'b11;
            end
        end
        chk("a_ack_count", got, n);
    endtask

    task automatic run_acks_b(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (b_ack != 0) begin
                got++;
                $display("B ack=%b t=%0t", b_ack, $time);
                req_b = req_b & ~b_ack;
            end
        end
        chk("b_ack_count", got, n);
    endtask

    task automatic wait_grant_a(output logic [1:0] g);
        int c = 0;
        while (c < 200 && a_grant == 2'b00) begin
            @(negedge clk);
            c++;
        end
        g = a_grant;
    endtask

    // ---------------- directed sequence ----------------
    logic [1:0]  g;
    int          dv_base, rx_base, g_base, ack_base, n;
    logic [7:0]  rr_bytes [0:7];
    logic [1:0]  rr_grants [0:3];

    initial begin
        // Reset for 3 cycles with both requests pending.
        rst   = 1'b1;
        req_a = 2'b11;
        msg_a = {16'hC33C, 16'hA55A};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs", {a_grant, a_ack, a_busy, a_dv, a_byte}, 32'h0);
        end
        rst = 1'b0;

        // First grant goes to requester 0. Its DV follows one cycle later.
        @(negedge clk);
        chk("first_grant", a_grant, 2'b01);
        chk("busy_at_grant", a_busy, 1'b1);
        req_a = 2'b01;
        @(negedge clk);
        chk("grant_pulse_width", a_grant, 2'b00);
        chk("dv_latency", a_dv, 1'b1);
        chk("dv_first_byte", a_byte, 8'hA5);

        // Single message A55A through the transmitter.
        run_acks_a(1, 1'b0, 600);
        repeat (3) @(negedge clk);
        chk("single_dv_count", dv_log.size(), 2);
        chk("single_dv0", dv_at(0), 8'hA5);
        chk("single_dv1", dv_at(1), 8'h5A);
        chk("single_rx_count", rx_log.size(), 2);
        chk("single_rx0", rx_at(0), 8'hA5);
        chk("single_rx1", rx_at(1), 8'h5A);
        chk("single_ack_count", ack_log.size(), 1);
        chk("single_ack", ack_log[0], 2'b01);
        chk("single_busy_after", a_busy, 1'b0);
        chk("single_byte_held", a_byte, 8'h5A);

        // Round robin: both requesters re-raised after every ack.
        rst   = 1'b1;
        msg_a = {16'h7E81, 16'h3C4D};
        req_a = 2'b11;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        g_base  = g_log.size();
        rx_base = rx_log.size();
        run_acks_a(4, 1'b1, 3000);
        req_a = 2'b00;
        repeat (5) @(negedge clk);
        rr_grants = '{2'b01, 2'b10, 2'b01, 2'b10};
        rr_bytes  = '{8'h3C, 8'h4D, 8'h7E, 8'h81, 8'h3C, 8'h4D, 8'h7E, 8'h81};
        for (int i = 0; i < 4; i++) chk("rr_grant", g_at(g_base + i), rr_grants[i]);
        for (int i = 0; i < 8; i++) chk("rr_byte", rx_at(rx_base + i), rr_bytes[i]);

        // Message changes one cycle after the grant. The latched copy is sent.
        msg_a   = {16'h0000, 16'h1234};
        dv_base = dv_log.size();
        rx_base = rx_log.size();
        req_a   = 2'b01;
        wait_grant_a(g);
        chk("midflight_grant", g, 2'b01);
        @(negedge clk);
        msg_a = {16'h0000, 16'hFFFF};
        run_acks_a(1, 1'b0, 600);
        repeat (3) @(negedge clk);
        chk("midflight_dv0", dv_at(dv_base), 8'h12);
        chk("midflight_dv1", dv_at(dv_base + 1), 8'h34);
        chk("midflight_rx0", rx_at(rx_base), 8'h12);
        chk("midflight_rx1", rx_at(rx_base + 1), 8'h34);

        // Reset during WAIT2_DONE: no ack. The pointer returns to 0, and
        // the last ack above was for requester 0, which left the pointer at 1.
        msg_a = {16'h2468, 16'hBEEF};
        req_a = 2'b01;
        wait_grant_a(g);
        chk("abort_grant", g, 2'b01);
        n = 0;
        for (int c = 0; c < 600 && n < 2; c++) begin
            @(negedge clk);
            if (a_dv) n++;
        end
        chk("abort_second_dv_seen", n, 2);
        @(negedge clk);
        ack_base = ack_log.size();
        rst      = 1'b1;
        req_a    = 2'b00;
        @(negedge clk);
        chk("abort_reset_outputs", {a_grant, a_ack, a_busy, a_dv, a_byte}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_no_ack", ack_log.size(), ack_base);
        chk("abort_idle_busy", a_busy, 1'b0);
        req_a = 2'b11;
        wait_grant_a(g);
        chk("after_abort_grant", g, 2'b01);
        req_a = 2'b01;
        @(negedge clk);
        chk("after_abort_dv_byte", a_byte, 8'hBE);
        run_acks_a(1, 1'b0, 600);
        chk("after_abort_ack", ack_log[ack_log.size() - 1], 2'b01);

        // Wrap with 3 requesters: serve 1 so the pointer moves to 2, then
        // with {2,0} pending the order is 2 then 0.
        req_b = 3'b010;
        run_acks_b(1, 300);
        req_b = 3'b101;
        run_acks_b(2, 600);
        repeat (2) @(negedge clk);
        chk("wrap_grant0", bg_at(0), 3'b010);
        chk("wrap_grant1", bg_at(1), 3'b100);
        chk("wrap_grant2", bg_at(2), 3'b001);
        chk("wrap_last_byte", b_byte, 8'h11);
        chk("wrap_busy_idle", b_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
